vend_controller: RTL and testbench

Transaction sequencer for the coin-operated vending machine. Accumulates credit from 5/10/25-kurus coin pulses and starts the product dispenser when credit reaches PRICE. Pays change or refunds in 5-kurus units through the change unit. Sits between the coin-acceptor front end and the dispenser/change-unit actuators, and owns both req/ack handshakes and their timeouts.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_ack_timer.sv | 29 ++
 rtl/vend_controller.sv | 155 +++++++++++++++
 tb/tb_vend_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the vending machine transaction sequencer.
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_CHANGE,
        S_REFUND,
        S_FAULT
    } statetype;

    localparam logic [4:0] COIN_5  = 5'd5;
    localparam logic [4:0] COIN_10 = 5'd10;
    localparam logic [4:0] COIN_25 = 5'd25;

    // Returns 0 unless exactly one coin line is high.
    function automatic logic [4:0] coin_value(input logic five, input logic ten, input logic tf);
        logic [4:0] v;
        case ({five, ten, tf})
            3'b100:  v = COIN_5;
            3'b010:  v = COIN_10;
            3'b001:  v = COIN_25;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// Req/ack watchdog: counts cycles a request waits without acknowledge.
module vend_ack_timer #(
    parameter int TMO_W       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic ack,
    output logic expired
);

    logic [TMO_W-1:0] r_count;

    // Fires on the cycle whose edge would bring the count to ACK_TIMEOUT.
    assign expired = run && !ack && (r_count == TMO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run && !ack && (r_count != TMO_W'(ACK_TIMEOUT))) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit accumulation, dispense and change/refund
// handshakes with timeout supervision.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE       = 25,
    parameter int CREDIT_W    = 6,
    parameter int ACK_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fiveKurus,
    input  logic                tenKurus,
    input  logic                twentyFiveKurus,
    input  logic                cancel,
    output logic                dispenseReq,
    input  logic                dispenseAck,
    output logic                changeReq,
    input  logic                changeAck,
    input  logic                faultClear,
    output logic                coinAccept,
    output logic                coinReject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                fault
);

    localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] LP_UNIT  = CREDIT_W'(5);

    statetype            r_state;
    statetype            w_next_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_next_credit;
    logic                r_disp_req;
    logic                r_chg_req;
    logic                r_coin_accept;
    logic                r_coin_reject;
    logic                w_accept;
    logic                w_reject;
    logic                w_any_coin;
    logic [4:0]          w_coin_val;
    logic                w_transfer;
    logic                w_disp_done;
    logic                w_state_chg;
    logic                w_disp_exp;
    logic                w_chg_exp;

    assign w_any_coin  = fiveKurus | tenKurus | twentyFiveKurus;
    assign w_coin_val  = coin_value(fiveKurus, tenKurus, twentyFiveKurus);
    assign w_transfer  = r_chg_req & changeAck;
    assign w_disp_done = r_disp_req & dispenseAck;
    assign w_state_chg = (w_next_state != r_state);

    vend_ack_timer #(.TMO_W(TMO_W), .ACK_TIMEOUT(ACK_TIMEOUT)) u_disp_tmr (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_state_chg),
        .run     (r_disp_req),
        .ack     (dispenseAck),
        .expired (w_disp_exp)
    );

    vend_ack_timer #(.TMO_W(TMO_W), .ACK_TIMEOUT(ACK_TIMEOUT)) u_chg_tmr (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_state_chg | w_transfer),
        .run     (r_chg_req),
        .ack     (changeAck),
        .expired (w_chg_exp)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_credit = r_credit;
        w_accept      = 1'b0;
        w_reject      = 1'b0;
        case (r_state)
            S_IDLE, S_COLLECT: begin
                // A cancel only takes effect with credit held; otherwise the coin is processed.
                if (cancel && (r_credit != '0)) begin
                    w_next_state = S_REFUND;
                    w_reject     = w_any_coin;
                end else if (w_any_coin) begin
                    if (w_coin_val == '0) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept      = 1'b1;
                        w_next_credit = r_credit + CREDIT_W'(w_coin_val);
                        w_next_state  = (w_next_credit >= LP_PRICE) ? S_DISPENSE : S_COLLECT;
                    end
                end
            end
            S_DISPENSE: begin
                w_reject = w_any_coin;
                if (w_disp_done) begin
                    w_next_credit = r_credit - LP_PRICE;
                    w_next_state  = (w_next_credit != '0) ? S_CHANGE : S_IDLE;
                end else if (w_disp_exp) begin
                    w_next_state = S_FAULT;
                end
            end
            S_CHANGE, S_REFUND: begin
                w_reject = w_any_coin;
                if (w_transfer) begin
                    w_next_credit = r_credit - LP_UNIT;
                    if (w_next_credit == '0) begin
                        w_next_state = S_IDLE;
                    end
                end else if (w_chg_exp) begin
                    w_next_state = S_FAULT;
                end
            end
            S_FAULT: begin
                w_reject = w_any_coin;
                if (faultClear) begin
                    w_next_state = (r_credit != '0) ? S_REFUND : S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_disp_req    <= 1'b0;
            r_chg_req     <= 1'b0;
            r_coin_accept <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_credit      <= w_next_credit;
            r_disp_req    <= (w_next_state == S_DISPENSE);
            r_chg_req     <= ((w_next_state == S_CHANGE) || (w_next_state == S_REFUND))
                             && (w_next_credit != '0);
            r_coin_accept <= w_accept;
            r_coin_reject <= w_reject;
        end
    end

    assign dispenseReq = r_disp_req;
    assign changeReq   = r_chg_req;
    assign coinAccept  = r_coin_accept;
    assign coinReject  = r_coin_reject;
    assign credit      = r_credit;
    assign fault       = (r_state == S_FAULT);
    assign busy        = (r_state == S_DISPENSE) || (r_state == S_CHANGE) ||
                         (r_state == S_REFUND)   || (r_state == S_FAULT);

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_vend_controller;

    localparam int PRICE       = 25;
    localparam int CREDIT_W    = 6;
    localparam int ACK_TIMEOUT = 255;
    localparam int TMO_W       = 8;

    localparam int MD_COLLECT = 0;
    localparam int MD_DISP    = 1;
    localparam int MD_PAY     = 2;
    localparam int MD_FAULT   = 3;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                fiveKurus = 1'b0;
    logic                tenKurus = 1'b0;
    logic                twentyFiveKurus = 1'b0;
    logic                cancel = 1'b0;
    logic                dispenseAck = 1'b0;
    logic                changeAck = 1'b0;
    logic                faultClear = 1'b0;
    logic                dispenseReq;
    logic                changeReq;
    logic                coinAccept;
    logic                coinReject;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                fault;

    int n_cmp = 0;
    int n_bad = 0;

    int m_mode;
    int m_credit;
    int m_wait;
    bit m_acc;
    bit m_rej;

    always #5 clock = ~clock;

    vend_controller #(
        .PRICE       (PRICE),
        .CREDIT_W    (CREDIT_W),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TMO_W       (TMO_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .fiveKurus       (fiveKurus),
        .tenKurus        (tenKurus),
        .twentyFiveKurus (twentyFiveKurus),
        .cancel          (cancel),
        .dispenseReq     (dispenseReq),
        .dispenseAck     (dispenseAck),
        .changeReq       (changeReq),
        .changeAck       (changeAck),
        .faultClear      (faultClear),
        .coinAccept      (coinAccept),
        .coinReject      (coinReject),
        .credit          (credit),
        .busy            (busy),
        .fault           (fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = MD_COLLECT;
        m_credit = 0;
        m_wait   = 0;
        m_acc    = 1'b0;
        m_rej    = 1'b0;
    endtask

    // Waiting on a handshake: count one stalled cycle, fault after ACK_TIMEOUT of them.
    task automatic model_stall();
        m_wait++;
        if (m_wait == ACK_TIMEOUT) begin
            m_mode = MD_FAULT;
            m_wait = 0;
        end
    endtask

    task automatic model_step();
        int n;
        int v;
        m_acc = 1'b0;
        m_rej = 1'b0;
        if (!reset) begin
            model_reset();
            return;
        end
        n = int'(fiveKurus) + int'(tenKurus) + int'(twentyFiveKurus);
        v = fiveKurus ? 5 : (tenKurus ? 10 : 25);
        case (m_mode)
            MD_COLLECT: begin
                if (cancel && m_credit > 0) begin
                    m_mode = MD_PAY;
                    m_wait = 0;
                    m_rej  = (n > 0);
                end else if (n == 1) begin
                    m_acc    = 1'b1;
                    m_credit = m_credit + v;
                    if (m_credit >= PRICE) begin
                        m_mode = MD_DISP;
                        m_wait = 0;
                    end
                end else if (n > 1) begin
                    m_rej = 1'b1;
                end
            end
            MD_DISP: begin
                m_rej = (n > 0);
                if (dispenseAck) begin
                    m_credit = m_credit - PRICE;
                    m_mode   = (m_credit > 0) ? MD_PAY : MD_COLLECT;
                    m_wait   = 0;
                end else begin
                    model_stall();
                end
            end
            MD_PAY: begin
                m_rej = (n > 0);
                if (changeAck) begin
                    m_credit = m_credit - 5;
                    m_wait   = 0;
                    if (m_credit == 0) m_mode = MD_COLLECT;
                end else begin
                    model_stall();
                end
            end
            default: begin
                m_rej = (n > 0);
                if (faultClear) begin
                    m_mode = (m_credit > 0) ? MD_PAY : MD_COLLECT;
                    m_wait = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        check_eq("credit", credit, m_credit);
        check_eq("dispenseReq", dispenseReq, (m_mode == MD_DISP));
        check_eq("changeReq", changeReq, (m_mode == MD_PAY) && (m_credit > 0));
        check_eq("coinAccept", coinAccept, m_acc);
        check_eq("coinReject", coinReject, m_rej);
        check_eq("busy", busy, (m_mode != MD_COLLECT));
        check_eq("fault", fault, (m_mode == MD_FAULT));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
        fiveKurus       = 1'b0;
        tenKurus        = 1'b0;
        twentyFiveKurus = 1'b0;
        cancel          = 1'b0;
        faultClear      = 1'b0;
    endtask

    task automatic coin(input int v);
        fiveKurus       = (v == 5);
        tenKurus        = (v == 10);
        twentyFiveKurus = (v == 25);
        tick();
    endtask

    task automatic acks(input int n_chg);
        changeAck = 1'b1;
        repeat (n_chg) tick();
        changeAck = 1'b0;
    endtask

    initial begin
        int cnt;
        int r;
        model_reset();
        #1;
        check_outputs();
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Exact price, no change
        coin(5);
        check_eq("t1_credit5", credit, 5);
        coin(10);
        coin(10);
        check_eq("t1_dispense", dispenseReq, 1);
        dispenseAck = 1'b1;
        tick();
        dispenseAck = 1'b0;
        check_eq("t1_credit0", credit, 0);
        tick();

        // Overpay then four change coins
        coin(10);
        coin(10);
        coin(25);
        check_eq("t2_credit45", credit, 45);
        dispenseAck = 1'b1;
        tick();
        dispenseAck = 1'b0;
        check_eq("t2_credit20", credit, 20);
        acks(4);
        tick();

        // Cancel refund
        coin(10);
        coin(5);
        cancel = 1'b1;
        tick();
        acks(3);
        check_eq("t3_idle", busy, 0);

        // Rejections
        fiveKurus = 1'b1;
        tenKurus  = 1'b1;
        tick();
        check_eq("t4_multihot", coinReject, 1);
        coin(10);
        coin(25);
        dispenseAck = 1'b1;
        tick();
        dispenseAck = 1'b0;
        coin(10);
        check_eq("t4_chg_coin", coinReject, 1);
        acks(2);
        coin(5);
        cancel   = 1'b1;
        tenKurus = 1'b1;
        tick();
        check_eq("t4_cancel_rej", coinReject, 1);
        acks(1);

        // Dispense timeout
        coin(25);
        cnt = 0;
        while (!fault && cnt < 300) begin
            tick();
            cnt++;
        end
        check_eq("t5_timeout_cycles", cnt, ACK_TIMEOUT);
        check_eq("t5_credit_kept", credit, 25);
        faultClear = 1'b1;
        tick();
        acks(5);
        tick();

        // Asynchronous reset mid-change
        coin(10);
        coin(10);
        coin(25);
        dispenseAck = 1'b1;
        tick();
        dispenseAck = 1'b0;
        acks(1);
        check_eq("t6_credit15", credit, 15);
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("t6_async_credit", credit, 0);
        check_outputs();
        tick();
        reset = 1'b1;
        coin(5);
        check_eq("t6_accept", coinAccept, 1);

        // Randomized traffic with periodic handshake stalls
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 15));
            fiveKurus       = (r == 0) || (r == 3) || (r == 4);
            tenKurus        = (r == 1) || (r == 4);
            twentyFiveKurus = (r == 2) || (r == 3) || (r == 4);
            cancel          = ($urandom_range(0, 15) == 0);
            faultClear      = ($urandom_range(0, 19) == 0);
            if ((i % 1000) >= 500 && (i % 1000) < 800) begin
                dispenseAck = 1'b0;
                changeAck   = 1'b0;
            end else begin
                dispenseAck = ($urandom_range(0, 2) == 0);
                changeAck   = ($urandom_range(0, 2) == 0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
